// File: rtl/ripple_carry_adder_4bit.sv
// Registered 4-bit ripple-carry adder: four chained full-adder cells feeding an output register.
// Define RCA_OVF_EN to add the registered two's-complement overflow flag `ovf`.

module rca_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);

  logic p;

  assign p    = a_i ^ b_i;
  assign s_o  = p ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & p);

endmodule

module ripple_carry_adder_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] s,
  output logic       co
`ifdef RCA_OVF_EN
  ,
  output logic       ovf
`endif
);

  logic [4:0] carry;
  logic [3:0] s_d;
  logic [3:0] s_q;
  logic       co_d;
  logic       co_q;

  assign carry[0] = c;

  // Stage p0: true ripple chain, carry[i+1] depends only on cell i
  for (genvar i = 0; i < 4; i++) begin : g_cell
    rca_full_adder u_fa (
      .a_i  (a[i]),
      .b_i  (b[i]),
      .ci_i (carry[i]),
      .s_o  (s_d[i]),
      .co_o (carry[i+1])
    );
  end

  assign co_d = carry[4];

  // Stage p1: output register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= 4'h0;
      co_q <= 1'b0;
    end else begin
      s_q  <= s_d;
      co_q <= co_d;
    end
  end

  assign s  = s_q;
  assign co = co_q;

`ifdef RCA_OVF_EN
  logic ovf_d;
  logic ovf_q;

  // Signed overflow: carry into the sign bit disagrees with carry out of it
  assign ovf_d = carry[4] ^ carry[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Self-checking bench for ripple_carry_adder_4bit; expected results come from plain integer arithmetic.
// Covers reset, directed vectors, async reset mid-stream, exhaustive and random back-to-back streams.

module tb_ripple_carry_adder_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c;
  logic [3:0] s;
  logic       co;
`ifdef RCA_OVF_EN
  logic       ovf;
`endif

  int total;
  int bad;

  ripple_carry_adder_4bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .s     (s),
    .co    (co)
`ifdef RCA_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned 5-bit sum of the operands
  function automatic logic [4:0] ref_sum(input int ai, input int bi, input int ci);
    int t;
    t = ai + bi + ci;
    return t[4:0];
  endfunction

  // Reference: signed result of a+b+c falls outside the 4-bit two's-complement range
  function automatic logic ref_ovf(input int ai, input int bi, input int ci);
    int sa, sb, t;
    sa = (ai >= 8) ? ai - 16 : ai;
    sb = (bi >= 8) ? bi - 16 : bi;
    t  = sa + sb + ci;
    return (t > 7 || t < -8);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a = 4'h5; b = 4'h3; c = 1'b1;
    #1;
    total++;
    if ({co, s} !== 5'h00) begin
      bad++;
      $display("FAIL reset_initial: got co,s=%h want 00", {co, s});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if ({co, s} !== 5'h00) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got co,s=%h want 00", i, {co, s});
      end
`ifdef RCA_OVF_EN
      total++;
      if (ovf !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold_ovf[%0d]: got %b want 0", i, ovf);
      end
`endif
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h09) begin
      bad++;
      $display("FAIL reset_release: got co,s=%h want 09", {co, s});
    end
  endtask

  task automatic test_small_sweep();
    logic [4:0] exp;
    for (int v = 1; v < 8; v++) begin
      @(negedge clk);
      a = {3'b000, v[2]}; b = {3'b000, v[1]}; c = v[0];
      exp = ref_sum(v[2], v[1], v[0]);
      @(posedge clk); #1;
      total++;
      if ({co, s} !== exp) begin
        bad++;
        $display("FAIL small_sweep a=%0d b=%0d c=%0d: got co,s=%h want %h", v[2], v[1], v[0], {co, s}, exp);
      end
    end
  endtask

  task automatic test_carry_ripple();
    @(negedge clk); a = 4'hF; b = 4'h0; c = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h10) begin
      bad++;
      $display("FAIL ripple_F_0_1: got co,s=%h want 10", {co, s});
    end
    @(negedge clk); a = 4'hF; b = 4'hF; c = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h1F) begin
      bad++;
      $display("FAIL ripple_F_F_1: got co,s=%h want 1f", {co, s});
    end
    @(negedge clk); a = 4'h0; b = 4'h0; c = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h00) begin
      bad++;
      $display("FAIL zero_sum: got co,s=%h want 00", {co, s});
    end
  endtask

`ifdef RCA_OVF_EN
  task automatic test_overflow();
    int va [3] = '{7, 8, 15};
    int vb [3] = '{1, 8, 1};
    int wo [3] = '{1, 1, 0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); a = va[i][3:0]; b = vb[i][3:0]; c = 1'b0;
      @(posedge clk); #1;
      total++;
      if (ovf !== wo[i][0]) begin
        bad++;
        $display("FAIL overflow[%0d]: got ovf=%b want %0d", i, ovf, wo[i]);
      end
      total++;
      if ({co, s} !== ref_sum(va[i], vb[i], 0)) begin
        bad++;
        $display("FAIL overflow_sum[%0d]: got co,s=%h want %h", i, {co, s}, ref_sum(va[i], vb[i], 0));
      end
    end
  endtask
`endif

  task automatic test_async_reset_mid();
    @(negedge clk); a = 4'hA; b = 4'h7; c = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h11) begin
      bad++;
      $display("FAIL mid_pre_reset: got co,s=%h want 11", {co, s});
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({co, s} !== 5'h00) begin
      bad++;
      $display("FAIL mid_async_clear: got co,s=%h want 00", {co, s});
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({co, s} !== 5'h11) begin
      bad++;
      $display("FAIL mid_release: got co,s=%h want 11", {co, s});
    end
  endtask

  task automatic test_exhaustive();
    logic [4:0] exp;
    for (int v = 0; v < 512; v++) begin
      @(negedge clk);
      a = v[8:5]; b = v[4:1]; c = v[0];
      @(posedge clk); #1;
      exp = ref_sum(v[8:5], v[4:1], v[0]);
      total++;
      if ({co, s} !== exp) begin
        bad++;
        $display("FAIL exhaustive a=%h b=%h c=%b: got co,s=%h want %h", v[8:5], v[4:1], v[0], {co, s}, exp);
      end
`ifdef RCA_OVF_EN
      total++;
      if (ovf !== ref_ovf(v[8:5], v[4:1], v[0])) begin
        bad++;
        $display("FAIL exhaustive_ovf a=%h b=%h c=%b: got %b want %b", v[8:5], v[4:1], v[0], ovf, ref_ovf(v[8:5], v[4:1], v[0]));
      end
`endif
    end
  endtask

  task automatic test_back_to_back_random();
    int ra, rb, rc;
    logic [4:0] exp;
    for (int i = 0; i < 200; i++) begin
      ra = int'($urandom_range(15, 0));
      rb = int'($urandom_range(15, 0));
      rc = int'($urandom_range(1, 0));
      @(negedge clk);
      a = ra[3:0]; b = rb[3:0]; c = rc[0];
      @(posedge clk); #1;
      exp = ref_sum(ra, rb, rc);
      total++;
      if ({co, s} !== exp) begin
        bad++;
        $display("FAIL random a=%0d b=%0d c=%0d: got co,s=%h want %h", ra, rb, rc, {co, s}, exp);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    a = 4'h0; b = 4'h0; c = 1'b0;
    test_reset();
    test_small_sweep();
    test_carry_ripple();
`ifdef RCA_OVF_EN
    test_overflow();
`endif
    test_async_reset_mid();
    test_exhaustive();
    test_back_to_back_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
